cdc_cmd_responder: RTL and testbench

Application-side endpoint for the usb_cdc byte streams. It consumes host-to-device bytes from the usb_cdc OUT stream, parses a binary register-access protocol, and produces device-to-host response bytes on the usb_cdc IN stream. It replaces the direct OUT-to-IN echo path with a small register file that the host can read and write. It sits beside u_usb_cdc in the same 48 MHz clock domain, with USE_APP_CLK=0.

---
 rtl/cdc_cmd_responder.sv | 175 +++++++++++++++++
 tb/tb_cdc_cmd_responder.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cdc_cmd_responder.sv
// Register-access command responder on the usb_cdc byte streams.
// Parses R/W/P commands from the OUT stream and answers on the IN stream.
module cdc_cmd_responder #(
  parameter int NUM_REGS       = 8,
  parameter int TIMEOUT_CYCLES = 12000000,
  parameter int CNT_W          = $clog2(TIMEOUT_CYCLES+1)
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic [7:0]            out_data_i,
  input  logic                  out_valid_i,
  output logic                  out_ready_o,
  output logic [7:0]            in_data_o,
  output logic                  in_valid_o,
  input  logic                  in_ready_i,
  output logic [NUM_REGS*8-1:0] regs_o,
  output logic [7:0]            err_cnt_o
);

  typedef enum logic [2:0] {
    IDLE, GET_ADDR, GET_DATA, RESP0, RESP1
  } state_e;

  localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [8:0]       NRG = 9'(NUM_REGS);

  state_e           state_q;
  logic             is_wr_q;
  logic [7:0]       addr_q;
  logic             addr_ok_q;
  logic             two_q;
  logic [7:0]       rd_q;
  logic [7:0]       in_data_q;
  logic             in_valid_q;
  logic [CNT_W-1:0] cnt_q;
  logic [7:0]       err_q;
  logic [7:0]       regs_q [NUM_REGS];

  logic             acc;
  logic             addr_ok_d;
  logic [7:0]       rd_d;
  logic [7:0]       err_d;
  logic [CNT_W-1:0] cnt_d;
  logic             tmo;

  assign out_ready_o = (state_q == IDLE) ||
                       (state_q == GET_ADDR) ||
                       (state_q == GET_DATA);
  assign acc       = out_valid_i & out_ready_o;
  assign addr_ok_d = {1'b0, out_data_i} < NRG;
  assign err_d     = (err_q == 8'hFF) ? err_q : err_q + 8'd1;
  assign cnt_d     = cnt_q + CNT_W'(1);
  assign tmo       = (cnt_d == TMO);

  always_comb begin
    rd_d = 8'h00;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (out_data_i == 8'(k)) rd_d = regs_q[k];
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q    <= IDLE;
      is_wr_q    <= 1'b0;
      addr_q     <= 8'h00;
      addr_ok_q  <= 1'b0;
      two_q      <= 1'b0;
      rd_q       <= 8'h00;
      in_data_q  <= 8'h00;
      in_valid_q <= 1'b0;
      cnt_q      <= '0;
      err_q      <= 8'h00;
      for (int k = 0; k < NUM_REGS; k++) regs_q[k] <= 8'h00;
    end else begin
      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (acc) begin
            two_q <= 1'b0;
            case (out_data_i)
              8'h52: begin
                is_wr_q <= 1'b0;
                state_q <= GET_ADDR;
              end
              8'h57: begin
                is_wr_q <= 1'b1;
                state_q <= GET_ADDR;
              end
              8'h50: begin
                in_data_q  <= 8'h70;
                in_valid_q <= 1'b1;
                state_q    <= RESP0;
              end
              default: begin
                in_data_q  <= 8'h3F;
                in_valid_q <= 1'b1;
                state_q    <= RESP0;
              end
            endcase
          end
        end
        GET_ADDR: begin
          if (acc) begin
            cnt_q     <= '0;
            addr_q    <= out_data_i;
            addr_ok_q <= addr_ok_d;
            if (is_wr_q) begin
              state_q <= GET_DATA;
            end else begin
              // Read data is captured now so it reflects every earlier write
              rd_q       <= rd_d;
              two_q      <= addr_ok_d;
              in_data_q  <= addr_ok_d ? 8'h72 : 8'h3F;
              in_valid_q <= 1'b1;
              state_q    <= RESP0;
            end
          end else if (tmo) begin
            cnt_q   <= '0;
            err_q   <= err_d;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        GET_DATA: begin
          if (acc) begin
            cnt_q <= '0;
            for (int k = 0; k < NUM_REGS; k++) begin
              if (addr_ok_q && addr_q == 8'(k)) regs_q[k] <= out_data_i;
            end
            in_data_q  <= addr_ok_q ? 8'h6B : 8'h3F;
            in_valid_q <= 1'b1;
            state_q    <= RESP0;
          end else if (tmo) begin
            cnt_q   <= '0;
            err_q   <= err_d;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        RESP0: begin
          if (in_ready_i) begin
            if (in_data_q == 8'h3F) err_q <= err_d;
            if (two_q) begin
              in_data_q <= rd_q;
              state_q   <= RESP1;
            end else begin
              in_valid_q <= 1'b0;
              state_q    <= IDLE;
            end
          end
        end
        RESP1: begin
          if (in_ready_i) begin
            in_valid_q <= 1'b0;
            two_q      <= 1'b0;
            state_q    <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  for (genvar k = 0; k < NUM_REGS; k++) begin : g_regs
    assign regs_o[8*k +: 8] = regs_q[k];
  end

  assign in_data_o  = in_data_q;
  assign in_valid_o = in_valid_q;
  assign err_cnt_o  = err_q;

endmodule

// File: tb/tb_cdc_cmd_responder.sv
// Scoreboard bench for cdc_cmd_responder.
// Expected IN bytes are queued at stimulus time and popped on transfer.
module tb_cdc_cmd_responder;

  localparam int NR = 8;

  logic          clk = 1'b0;
  logic          rstn_i;
  logic [7:0]    out_data_i;
  logic          out_valid_i;
  logic          out_ready_o;
  logic [7:0]    in_data_o;
  logic          in_valid_o;
  logic          in_ready_i;
  logic [NR*8-1:0] regs_o;
  logic [7:0]    err_cnt_o;

  int            n_chk = 0;
  int            n_fail = 0;
  logic [7:0]    exp_q [$];
  logic [7:0]    m_regs [NR];
  logic [7:0]    exp_err;

  cdc_cmd_responder #(
    .NUM_REGS(NR),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk_i      (clk),
    .rstn_i     (rstn_i),
    .out_data_i (out_data_i),
    .out_valid_i(out_valid_i),
    .out_ready_o(out_ready_o),
    .in_data_o  (in_data_o),
    .in_valid_o (in_valid_o),
    .in_ready_i (in_ready_i),
    .regs_o     (regs_o),
    .err_cnt_o  (err_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rstn_i && in_valid_o && in_ready_i) begin
      if (exp_q.size() == 0) chk("rsp_unexpected", in_valid_o, 1'b0);
      else chk("rsp_byte", in_data_o, exp_q.pop_front());
    end
  end

  function automatic logic [63:0] model_flat();
    logic [63:0] f;
    for (int k = 0; k < NR; k++) f[8*k +: 8] = m_regs[k];
    return f;
  endfunction

  function automatic void bump_err();
    if (exp_err != 8'hFF) exp_err = exp_err + 8'd1;
  endfunction

  task automatic send(input logic [7:0] b);
    bit acc;
    int n;
    out_data_i  = b;
    out_valid_i = 1'b1;
    acc = 0;
    n = 0;
    while (!acc && n < 400) begin
      @(negedge clk);
      acc = out_ready_o;
      @(posedge clk);
      #2;
      n++;
    end
    out_valid_i = 1'b0;
    if (!acc) chk("send_accept", acc, 1'b1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || in_valid_o) && n < 400) begin
      @(posedge clk);
      n++;
    end
    if (n > 0) #2;
    chk("drain", exp_q.size(), 0);
  endtask

  task automatic cmd_read(input logic [7:0] a);
    if (a < NR) begin
      exp_q.push_back(8'h72);
      exp_q.push_back(m_regs[a[2:0]]);
    end else begin
      exp_q.push_back(8'h3F);
      bump_err();
    end
    send(8'h52);
    send(a);
  endtask

  task automatic cmd_write(input logic [7:0] a, input logic [7:0] d);
    if (a < NR) begin
      exp_q.push_back(8'h6B);
      m_regs[a[2:0]] = d;
    end else begin
      exp_q.push_back(8'h3F);
      bump_err();
    end
    send(8'h57);
    send(a);
    send(d);
  endtask

  task automatic cmd_raw(input logic [7:0] b);
    if (b == 8'h50) exp_q.push_back(8'h70);
    else begin
      exp_q.push_back(8'h3F);
      bump_err();
    end
    send(b);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn_i      = 1'b0;
    out_data_i  = 8'h00;
    out_valid_i = 1'b0;
    in_ready_i  = 1'b1;
    exp_err     = 8'h00;
    for (int k = 0; k < NR; k++) m_regs[k] = 8'h00;
    #23;
    chk("rst_in_valid", in_valid_o, 1'b0);
    chk("rst_in_data", in_data_o, 8'h00);
    chk("rst_regs", regs_o, 64'h0);
    chk("rst_err", err_cnt_o, 8'h00);
    chk("rst_out_ready", out_ready_o, 1'b1);
    rstn_i = 1'b1;
    @(posedge clk);
    #2;

    // write then read back, back-to-back
    cmd_write(8'h03, 8'hA5);
    cmd_read(8'h03);
    drain();
    chk("t1_reg3", regs_o[31:24], 8'hA5);
    cmd_write(8'h07, 8'h5C);
    cmd_write(8'h00, 8'h3F);
    cmd_read(8'h07);
    cmd_read(8'h00);
    drain();
    chk("t1_regs", regs_o, model_flat());
    chk("t1_err", err_cnt_o, exp_err);

    // ping and unknown byte
    cmd_raw(8'h50);
    cmd_raw(8'h41);
    drain();
    chk("t2_err", err_cnt_o, exp_err);
    chk("t2_regs", regs_o, model_flat());

    // invalid addresses, including the all-ones boundary
    cmd_read(8'h08);
    cmd_write(8'h09, 8'hFF);
    cmd_write(8'hFF, 8'h11);
    cmd_read(8'h80);
    drain();
    chk("t3_err", err_cnt_o, exp_err);
    chk("t3_regs", regs_o, model_flat());

    // IN backpressure holds the first response byte
    in_ready_i = 1'b0;
    cmd_read(8'h01);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      chk("t4_valid", in_valid_o, 1'b1);
      chk("t4_data", in_data_o, 8'h72);
      chk("t4_oready", out_ready_o, 1'b0);
    end
    @(posedge clk);
    #2;
    in_ready_i = 1'b1;
    drain();

    // timeout of a partial write
    send(8'h57);
    repeat (14) @(posedge clk);
    #2;
    chk("t5_no_early_tmo", err_cnt_o, exp_err);
    repeat (6) @(posedge clk);
    #2;
    bump_err();
    chk("t5_err", err_cnt_o, exp_err);
    chk("t5_no_rsp", in_valid_o, 1'b0);
    cmd_raw(8'h50);
    drain();
    chk("t5_regs", regs_o, model_flat());

    // reset while a read response is pending
    in_ready_i = 1'b0;
    send(8'h52);
    send(8'h03);
    @(negedge clk);
    chk("t6_pending", in_valid_o, 1'b1);
    #2;
    rstn_i = 1'b0;
    #1;
    chk("t6_async_valid", in_valid_o, 1'b0);
    chk("t6_regs", regs_o, 64'h0);
    chk("t6_err", err_cnt_o, 8'h00);
    for (int k = 0; k < NR; k++) m_regs[k] = 8'h00;
    exp_err = 8'h00;
    repeat (2) @(negedge clk);
    rstn_i = 1'b1;
    in_ready_i = 1'b1;
    @(posedge clk);
    #2;
    cmd_raw(8'h50);
    cmd_read(8'h03);
    drain();
    chk("t6_err_after", err_cnt_o, exp_err);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
